// File: rtl/aes_pkg.sv
// Shared AES-128 types: command opcodes and the 32-bit word used on control/key buses.
package aes_pkg;

    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESDEC          = 3'd3,
        AESDECLAST      = 3'd4,
        AESIMC          = 3'd5,
        AESKEYGENASSIST = 3'd6,
        AESENCFULL      = 3'd7
    } opcode;

    typedef logic [31:0] aes_32;

endpackage

// File: rtl/aes_ctrl.sv
// Sequencing FSM for the AES-128 core: decodes a command and strobes the round datapath,
// S-box mux and key generator. Outputs are a decode of state, round count and latched opcode.
module aes_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic  clk,
    input  logic  nrst,
    input  logic  start_i,
    input  opcode opcode_i,
    output logic  full_enc_o,
    output logic  zero_rnd_o,
    output logic  key_sel_o,
    output logic  final_rnd_o,
    output logic  en_rnd_o,
    output logic  key_sub_o,
    output logic  en_key_o,
    output logic  gen_key_o,
    output logic  next_rnd_o,
    output logic  cipher_ready_o,
    output logic  key_ready_o,
    output logic  busy_o,
    output aes_32 r_con_ctrl_o
);

    localparam int unsigned RW = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        KEY  = 3'd2,
        RND  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rnd_q, rnd_d;
    opcode         op_q, op_d;

    // Round constant; index 0 serves the single KEYGENASSIST op, which uses rcon = 01.
    function automatic logic [7:0] rcon_of(input logic [RW-1:0] r);
        case (r)
            4'd0, 4'd1: rcon_of = 8'h01;
            4'd2:       rcon_of = 8'h02;
            4'd3:       rcon_of = 8'h04;
            4'd4:       rcon_of = 8'h08;
            4'd5:       rcon_of = 8'h10;
            4'd6:       rcon_of = 8'h20;
            4'd7:       rcon_of = 8'h40;
            4'd8:       rcon_of = 8'h80;
            4'd9:       rcon_of = 8'h1B;
            4'd10:      rcon_of = 8'h36;
            default:    rcon_of = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            op_q    <= NOOP;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rnd_d          = rnd_q;
        op_d           = op_q;
        full_enc_o     = 1'b0;
        zero_rnd_o     = 1'b0;
        key_sel_o      = 1'b0;
        final_rnd_o    = 1'b0;
        en_rnd_o       = 1'b0;
        key_sub_o      = 1'b0;
        en_key_o       = 1'b0;
        gen_key_o      = 1'b0;
        next_rnd_o     = 1'b0;
        cipher_ready_o = 1'b0;
        key_ready_o    = 1'b0;
        busy_o         = 1'b0;
        r_con_ctrl_o   = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d  = opcode_i;
                    rnd_d = '0;
                    case (opcode_i)
                        AESENCFULL:         state_d = INIT;
                        AESENC, AESENCLAST: state_d = RND;
                        AESKEYGENASSIST:    state_d = KEY;
                        default:            state_d = IDLE;
                    endcase
                end
            end
            INIT: begin
                full_enc_o = 1'b1;
                zero_rnd_o = 1'b1;
                en_rnd_o   = 1'b1;
                busy_o     = 1'b1;
                rnd_d      = RW'(1);
                state_d    = KEY;
            end
            KEY: begin
                full_enc_o   = (op_q == AESENCFULL);
                key_sub_o    = 1'b1;
                gen_key_o    = 1'b1;
                en_key_o     = 1'b1;
                busy_o       = 1'b1;
                r_con_ctrl_o = {rcon_of(rnd_q), 24'h0};
                state_d      = (op_q == AESENCFULL) ? RND : DONE;
            end
            RND: begin
                en_rnd_o = 1'b1;
                busy_o   = 1'b1;
                state_d  = DONE;
                if (op_q == AESENCFULL) begin
                    full_enc_o  = 1'b1;
                    key_sel_o   = 1'b1;
                    next_rnd_o  = 1'b1;
                    final_rnd_o = (rnd_q == RW'(NR));
                    // Alternate back to key expansion until the last round has run.
                    if (rnd_q < RW'(NR)) begin
                        rnd_d   = rnd_q + RW'(1);
                        state_d = KEY;
                    end
                end else begin
                    final_rnd_o = (op_q == AESENCLAST);
                end
            end
            DONE: begin
                cipher_ready_o = (op_q != AESKEYGENASSIST);
                key_ready_o    = (op_q == AESKEYGENASSIST);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_ctrl.sv
// Self-checking bench for aes_ctrl: per-cycle expected output vectors are queued with the
// stimulus and popped against the DUT outputs sampled on the falling edge.
module tb_aes_ctrl;
    import aes_pkg::*;

    logic  clk;
    logic  nrst;
    logic  start;
    opcode op;
    logic  full_enc, zero_rnd, key_sel, final_rnd, en_rnd, key_sub;
    logic  en_key, gen_key, next_rnd, cipher_ready, key_ready, busy;
    aes_32 r_con;

    logic [43:0] sb[$];
    int vectors;
    int miscompares;

    localparam logic [43:0] Z = 44'h0;

    aes_ctrl #(.NR(10)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_i        (start),
        .opcode_i       (op),
        .full_enc_o     (full_enc),
        .zero_rnd_o     (zero_rnd),
        .key_sel_o      (key_sel),
        .final_rnd_o    (final_rnd),
        .en_rnd_o       (en_rnd),
        .key_sub_o      (key_sub),
        .en_key_o       (en_key),
        .gen_key_o      (gen_key),
        .next_rnd_o     (next_rnd),
        .cipher_ready_o (cipher_ready),
        .key_ready_o    (key_ready),
        .busy_o         (busy),
        .r_con_ctrl_o   (r_con)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [43:0] ev(input logic fe, input logic zr, input logic ks,
                                       input logic fr, input logic er, input logic ksub,
                                       input logic ek, input logic gk, input logic nr,
                                       input logic cr, input logic kr, input logic bz,
                                       input logic [7:0] rc);
        return {fe, zr, ks, fr, er, ksub, ek, gk, nr, cr, kr, bz, rc, 24'h0};
    endfunction

    function automatic logic [43:0] obs();
        return {full_enc, zero_rnd, key_sel, final_rnd, en_rnd, key_sub,
                en_key, gen_key, next_rnd, cipher_ready, key_ready, busy, r_con};
    endfunction

    function automatic logic [7:0] rcon_of(input int i);
        case (i)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1B; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Expected vectors for one cycle of a full encryption
    function automatic logic [43:0] ev_init();
        return ev(1,1,0,0,1,0,0,0,0,0,0,1,8'h00);
    endfunction
    function automatic logic [43:0] ev_fkey(input int i);
        return ev(1,0,0,0,0,1,1,1,0,0,0,1,rcon_of(i));
    endfunction
    function automatic logic [43:0] ev_frnd(input int i);
        return ev(1,0,1,(i == 10),1,0,0,0,1,0,0,1,8'h00);
    endfunction

    task automatic abort_op();
        nrst = 1'b0; start = 1'b0; op = NOOP;
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        logic [43:0] act, e;
        nrst = 1'b0; start = 1'b0; op = NOOP;
        @(posedge clk); #1;
        for (int c = 0; c < 11; c++) sb.push_back(Z);
        for (int c = 0; c < 11; c++) begin
            if (c == 5) begin start = 1'b1; op = AESENCFULL; end
            if (c == 9) begin start = 1'b0; op = NOOP; end
            if (c == 10) nrst = 1'b1;
            @(negedge clk);
            act = obs(); e = sb.pop_front(); vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %h expected %h", c, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_enc();
        logic [43:0] act, e;
        int n;
        sb.push_back(Z);
        sb.push_back(ev_init());
        for (int i = 1; i <= 10; i++) begin
            sb.push_back(ev_fkey(i));
            sb.push_back(ev_frnd(i));
        end
        sb.push_back(ev(0,0,0,0,0,0,0,0,0,1,0,0,8'h00));
        sb.push_back(Z);
        sb.push_back(ev_init());
        n = sb.size();
        start = 1'b1; op = AESENCFULL;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            act = obs(); e = sb.pop_front(); vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL full_enc cyc %0d: got %h expected %h", c, act, e);
            end
            @(posedge clk); #1;
        end
        abort_op();
    endtask

    task automatic test_enc(input opcode o, input logic last);
        logic [43:0] act, e;
        sb.push_back(Z);
        sb.push_back(ev(0,0,0,last,1,0,0,0,0,0,0,1,8'h00));
        sb.push_back(ev(0,0,0,0,0,0,0,0,0,1,0,0,8'h00));
        sb.push_back(Z);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin start = 1'b1; op = o; end
            if (c == 1) begin start = 1'b0; op = NOOP; end
            @(negedge clk);
            act = obs(); e = sb.pop_front(); vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL enc(last=%0b) cyc %0d: got %h expected %h", last, c, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_keygen();
        logic [43:0] act, e;
        sb.push_back(Z);
        sb.push_back(ev(0,0,0,0,0,1,1,1,0,0,0,1,8'h01));
        sb.push_back(ev(0,0,0,0,0,0,0,0,0,0,1,0,8'h00));
        sb.push_back(Z);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin start = 1'b1; op = AESKEYGENASSIST; end
            if (c == 1) begin start = 1'b0; op = NOOP; end
            @(negedge clk);
            act = obs(); e = sb.pop_front(); vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL keygen cyc %0d: got %h expected %h", c, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unsupported();
        logic [43:0] act, e;
        opcode list[4];
        list[0] = AESDEC; list[1] = AESDECLAST; list[2] = AESIMC; list[3] = NOOP;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) sb.push_back(Z);
            start = 1'b1; op = list[k];
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                act = obs(); e = sb.pop_front(); vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL unsupported op %0d cyc %0d: got %h expected %h",
                             k, c, act, e);
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0; op = NOOP;
    endtask

    task automatic test_back_to_back();
        logic [43:0] act, e;
        sb.push_back(Z);
        sb.push_back(ev(0,0,0,0,1,0,0,0,0,0,0,1,8'h00));
        sb.push_back(ev(0,0,0,0,0,0,0,0,0,1,0,0,8'h00));
        sb.push_back(Z);
        sb.push_back(ev(0,0,0,0,0,1,1,1,0,0,0,1,8'h01));
        sb.push_back(ev(0,0,0,0,0,0,0,0,0,0,1,0,8'h00));
        sb.push_back(Z);
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: begin start = 1'b1; op = AESENC; end
                1: op = AESDEC;
                2: op = AESKEYGENASSIST;
                5: begin start = 1'b0; op = AESENCLAST; end
                default: ;
            endcase
            @(negedge clk);
            act = obs(); e = sb.pop_front(); vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", c, act, e);
            end
            @(posedge clk); #1;
        end
        op = NOOP;
    endtask

    task automatic test_mid_reset();
        logic [43:0] act, e;
        int n;
        sb.push_back(Z);
        sb.push_back(ev_init());
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(ev_fkey(i));
            sb.push_back(ev_frnd(i));
        end
        sb.push_back(Z);
        sb.push_back(Z);
        sb.push_back(Z);
        sb.push_back(ev_init());
        sb.push_back(ev_fkey(1));
        sb.push_back(ev_frnd(1));
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            case (c)
                0:  begin start = 1'b1; op = AESENCFULL; end
                1:  start = 1'b0;
                11: nrst = 1'b0;
                12: nrst = 1'b1;
                14: start = 1'b1;
                15: start = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            act = obs(); e = sb.pop_front(); vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL mid_reset cyc %0d: got %h expected %h", c, act, e);
            end
            @(posedge clk); #1;
        end
        abort_op();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nrst  = 1'b0;
        start = 1'b0;
        op    = NOOP;
        test_reset();
        test_full_enc();
        test_enc(AESENC, 1'b0);
        test_enc(AESENCLAST, 1'b1);
        test_keygen();
        test_unsupported();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
